// File: rtl/bus_responder12_if.sv
// Processor12 memory bus: word address, write data and write strobe from the
// processor, registered read data back to it. No handshake; one access per clock.
// Ports: address[23:0], wdata[11:0], mem_write (master->slave); rdata[11:0] (slave->master).
interface bus_responder12_if;
   logic [23:0] address;
   logic [11:0] wdata;
   logic        mem_write;
   logic [11:0] rdata;

   modport master (output address, output wdata, output mem_write, input rdata);
   modport slave  (input address, input wdata, input mem_write, output rdata);
endinterface

// File: rtl/bus_responder12.sv
// Memory-side responder for Processor12: internal RAM, interval timer, interrupt pending/mask page.
// Latency: read data registered, valid the cycle after the address; writes commit on the same edge.
// Backpressure: none, every cycle is an accepted access.
// Ports: clk, rst (async active-low), bus (slave modport), ext_irq[22:0] in, irq[23:0] out.
module bus_responder12 #(
   parameter int          RAM_AW  = 12,
   parameter logic [23:0] IO_BASE = 24'o77777700
) (
   input  logic              clk,
   input  logic              rst,
   bus_responder12_if.slave  bus,
   input  logic [22:0]       ext_irq,
   output logic [23:0]       irq
);

   localparam int          RAM_WORDS = 1 << RAM_AW;
   localparam logic [11:0] ID_VAL    = 12'o5412;

   // ---------------- address decode ----------------
   logic              is_ram;
   logic              is_io;
   logic [2:0]        io_off;
   logic [RAM_AW-1:0] ram_idx;

   assign is_ram  = (bus.address >> RAM_AW) == 24'd0;
   assign is_io   = bus.address[23:3] == IO_BASE[23:3];
   assign io_off  = bus.address[2:0];
   assign ram_idx = bus.address[RAM_AW-1:0];

   logic io_we;
   logic wr_tcnt, wr_trld, wr_tctl, wr_ipnd_l, wr_ipnd_h, wr_imsk_l, wr_imsk_h;

   assign io_we     = bus.mem_write && is_io;
   assign wr_tcnt   = io_we && (io_off == 3'o0);
   assign wr_trld   = io_we && (io_off == 3'o1);
   assign wr_tctl   = io_we && (io_off == 3'o2);
   assign wr_ipnd_l = io_we && (io_off == 3'o3);
   assign wr_ipnd_h = io_we && (io_off == 3'o4);
   assign wr_imsk_l = io_we && (io_off == 3'o5);
   assign wr_imsk_h = io_we && (io_off == 3'o6);

   // ---------------- RAM ----------------
   logic [11:0] mem [RAM_WORDS];

   // Contents survive reset, but a write strobe seen while reset is held must
   // not land; the empty reset branch gives exactly that without clearing data.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
      end else if (bus.mem_write && is_ram) begin
         mem[ram_idx] <= bus.wdata;
      end
   end

   // ---------------- registers ----------------
   logic [11:0] tcnt, trld;
   logic [1:0]  tctl;           // bit0 enable, bit1 auto-reload
   logic [23:0] pend, mask;
   logic [22:0] sync1, sync2, sync3;
   logic [11:0] rd_val;

   logic        tick;
   logic [11:0] tcnt_n;
   logic [1:0]  tctl_n;
   logic [23:0] pend_set, pend_clr;

   assign tick = tctl[0] && (tcnt == 12'd0);

   // Timer update first, then CPU writes override it for the written register.
   always_comb begin
      tcnt_n = tcnt;
      tctl_n = tctl;
      if (tctl[0]) begin
         if (tcnt != 12'd0)  tcnt_n = tcnt - 12'd1;
         else if (tctl[1])   tcnt_n = trld;
         else                tctl_n[0] = 1'b0;
      end
      if (wr_tcnt) tcnt_n = bus.wdata;
      if (wr_tctl) tctl_n = bus.wdata[1:0];
   end

   // sync2 is the last synchroniser stage; sync3 holds its previous value for edge detect.
   assign pend_set = {sync2 & ~sync3, tick};
   assign pend_clr = {(wr_ipnd_h ? bus.wdata : 12'd0), (wr_ipnd_l ? bus.wdata : 12'd0)};

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         tcnt      <= '0;
         trld      <= '0;
         tctl      <= '0;
         pend      <= '0;
         mask      <= '0;
         sync1     <= '0;
         sync2     <= '0;
         sync3     <= '0;
         bus.rdata <= '0;
      end else begin
         tcnt  <= tcnt_n;
         tctl  <= tctl_n;
         if (wr_trld)   trld        <= bus.wdata;
         if (wr_imsk_l) mask[11:0]  <= bus.wdata;
         if (wr_imsk_h) mask[23:12] <= bus.wdata;
         // Set beats clear when both hit the same bit in one cycle.
         pend      <= (pend & ~pend_clr) | pend_set;
         sync1     <= ext_irq;
         sync2     <= sync1;
         sync3     <= sync2;
         bus.rdata <= rd_val;
      end
   end

   // ---------------- read mux (pre-write values give read-before-write) ----------------
   always_comb begin
      rd_val = 12'd0;
      if (is_ram) begin
         rd_val = mem[ram_idx];
      end else if (is_io) begin
         case (io_off)
            3'o0:    rd_val = tcnt;
            3'o1:    rd_val = trld;
            3'o2:    rd_val = {10'd0, tctl};
            3'o3:    rd_val = pend[11:0];
            3'o4:    rd_val = pend[23:12];
            3'o5:    rd_val = mask[11:0];
            3'o6:    rd_val = mask[23:12];
            default: rd_val = ID_VAL;
         endcase
      end
   end

   assign irq = pend & mask;

endmodule

// File: tb/tb_bus_responder12.sv
// Directed self-checking bench for bus_responder12.
// Inputs driven and outputs sampled on the falling clock edge.
module tb_bus_responder12;

   localparam logic [23:0] A_TCNT   = 24'o77777700;
   localparam logic [23:0] A_TRLD   = 24'o77777701;
   localparam logic [23:0] A_TCTL   = 24'o77777702;
   localparam logic [23:0] A_IPND_L = 24'o77777703;
   localparam logic [23:0] A_IPND_H = 24'o77777704;
   localparam logic [23:0] A_IMSK_L = 24'o77777705;
   localparam logic [23:0] A_IMSK_H = 24'o77777706;
   localparam logic [23:0] A_ID     = 24'o77777707;
   localparam logic [23:0] A_HOLE   = 24'o00010000;

   logic        clk;
   logic        rst;
   logic [22:0] ext_irq;
   logic [23:0] irq;

   int vectors;
   int miscompares;

   bus_responder12_if bus ();

   bus_responder12 dut (
      .clk     (clk),
      .rst     (rst),
      .bus     (bus),
      .ext_irq (ext_irq),
      .irq     (irq)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // One write cycle: strobe presented for exactly one rising edge.
   task automatic do_write(input logic [23:0] a, input logic [11:0] d);
      bus.address   = a;
      bus.wdata     = d;
      bus.mem_write = 1'b1;
      @(negedge clk);
      bus.mem_write = 1'b0;
   endtask

   // One read cycle: address presented, data sampled one clock later.
   task automatic do_read(input logic [23:0] a, output logic [11:0] d);
      bus.address   = a;
      bus.mem_write = 1'b0;
      @(negedge clk);
      d = bus.rdata;
   endtask

   task automatic test_reset;
      logic [11:0] d;
      rst = 1'b0;
      @(negedge clk);
      @(negedge clk);
      vectors++;
      if (bus.rdata !== 12'd0) begin
         miscompares++;
         $display("FAIL reset_rdata got %o want %o", bus.rdata, 12'd0);
      end
      vectors++;
      if (irq !== 24'd0) begin
         miscompares++;
         $display("FAIL reset_irq got %o want %o", irq, 24'd0);
      end
      rst = 1'b1;
      do_read(A_ID, d);
      vectors++;
      if (d !== 12'o5412) begin
         miscompares++;
         $display("FAIL reset_id got %o want %o", d, 12'o5412);
      end
      do_read(A_TCTL, d);
      vectors++;
      if (d !== 12'd0) begin
         miscompares++;
         $display("FAIL reset_tctl got %o want %o", d, 12'd0);
      end
   endtask

   task automatic test_ram;
      logic [11:0] d;
      do_write(24'o00000005, 12'o1234);
      do_write(24'o00000000, 12'o7070);
      do_write(24'o00007777, 12'o0123);
      do_write(A_HOLE, 12'o5555);
      do_read(24'o00000005, d);
      vectors++;
      if (d !== 12'o1234) begin
         miscompares++;
         $display("FAIL ram_rd5 got %o want %o", d, 12'o1234);
      end
      do_read(24'o00000000, d);
      vectors++;
      if (d !== 12'o7070) begin
         miscompares++;
         $display("FAIL ram_rd0 got %o want %o", d, 12'o7070);
      end
      do_read(24'o00007777, d);
      vectors++;
      if (d !== 12'o0123) begin
         miscompares++;
         $display("FAIL ram_rd_top got %o want %o", d, 12'o0123);
      end
      do_read(A_HOLE, d);
      vectors++;
      if (d !== 12'd0) begin
         miscompares++;
         $display("FAIL hole_rd got %o want %o", d, 12'd0);
      end
   endtask

   task automatic test_rbw;
      logic [11:0] d;
      do_write(24'o00000007, 12'o0001);
      bus.address   = 24'o00000007;
      bus.wdata     = 12'o7777;
      bus.mem_write = 1'b1;
      @(negedge clk);
      bus.mem_write = 1'b0;
      vectors++;
      if (bus.rdata !== 12'o0001) begin
         miscompares++;
         $display("FAIL rbw_old got %o want %o", bus.rdata, 12'o0001);
      end
      do_read(24'o00000007, d);
      vectors++;
      if (d !== 12'o7777) begin
         miscompares++;
         $display("FAIL rbw_new got %o want %o", d, 12'o7777);
      end
   endtask

   task automatic test_timer_oneshot;
      logic [11:0] d;
      do_write(A_IMSK_L, 12'o0001);
      do_write(A_TCNT, 12'd3);
      do_write(A_TCTL, 12'd1);
      bus.address = A_HOLE;
      // Enabled edges 1..3 count 3->0; edge 4 fires.
      for (int i = 1; i <= 4; i++) begin
         @(negedge clk);
         vectors++;
         if (irq[0] !== (i == 4)) begin
            miscompares++;
            $display("FAIL oneshot_edge%0d irq0 got %b want %b", i, irq[0], (i == 4));
         end
      end
      do_read(A_TCTL, d);
      vectors++;
      if (d !== 12'd0) begin
         miscompares++;
         $display("FAIL oneshot_tctl got %o want %o", d, 12'd0);
      end
      do_read(A_TCNT, d);
      vectors++;
      if (d !== 12'd0) begin
         miscompares++;
         $display("FAIL oneshot_tcnt got %o want %o", d, 12'd0);
      end
      do_read(A_IPND_L, d);
      vectors++;
      if (d !== 12'o0001) begin
         miscompares++;
         $display("FAIL oneshot_ipnd got %o want %o", d, 12'o0001);
      end
      do_write(A_IPND_L, 12'o0001);
      vectors++;
      if (irq[0] !== 1'b0) begin
         miscompares++;
         $display("FAIL oneshot_clear irq0 got %b want %b", irq[0], 1'b0);
      end
   endtask

   task automatic test_timer_reload;
      do_write(A_TRLD, 12'd2);
      do_write(A_TCNT, 12'd0);
      do_write(A_TCTL, 12'd3);
      bus.address = A_HOLE;
      @(negedge clk);                       // E1: tick
      vectors++;
      if (irq[0] !== 1'b1) begin
         miscompares++;
         $display("FAIL reload_e1 got %b want %b", irq[0], 1'b1);
      end
      do_write(A_IPND_L, 12'o0001);         // E2: clear
      vectors++;
      if (irq[0] !== 1'b0) begin
         miscompares++;
         $display("FAIL reload_e2 got %b want %b", irq[0], 1'b0);
      end
      @(negedge clk);                       // E3
      vectors++;
      if (irq[0] !== 1'b0) begin
         miscompares++;
         $display("FAIL reload_e3 got %b want %b", irq[0], 1'b0);
      end
      @(negedge clk);                       // E4: tick
      vectors++;
      if (irq[0] !== 1'b1) begin
         miscompares++;
         $display("FAIL reload_e4 got %b want %b", irq[0], 1'b1);
      end
      do_write(A_IPND_L, 12'o0001);         // E5: clear
      do_write(A_IPND_L, 12'o0000);         // E6: writing 0 changes nothing
      vectors++;
      if (irq[0] !== 1'b0) begin
         miscompares++;
         $display("FAIL reload_e6 got %b want %b", irq[0], 1'b0);
      end
      do_write(A_IPND_L, 12'o0001);         // E7: clear collides with tick
      vectors++;
      if (irq[0] !== 1'b1) begin
         miscompares++;
         $display("FAIL reload_set_wins got %b want %b", irq[0], 1'b1);
      end
      do_write(A_TCTL, 12'd0);
      do_write(A_IPND_L, 12'o0001);
      @(negedge clk);
      @(negedge clk);
      @(negedge clk);
      vectors++;
      if (irq[0] !== 1'b0) begin
         miscompares++;
         $display("FAIL reload_stopped got %b want %b", irq[0], 1'b0);
      end
   endtask

   task automatic test_ext_irq;
      logic [11:0] d;
      do_write(A_IMSK_H, 12'o4000);
      bus.address = A_HOLE;
      ext_irq[22] = 1'b1;
      for (int i = 1; i <= 3; i++) begin
         @(negedge clk);
         vectors++;
         if (irq[23] !== (i == 3)) begin
            miscompares++;
            $display("FAIL ext_clk%0d irq23 got %b want %b", i, irq[23], (i == 3));
         end
      end
      do_write(A_IPND_H, 12'o0000);
      vectors++;
      if (irq[23] !== 1'b1) begin
         miscompares++;
         $display("FAIL ext_w0 irq23 got %b want %b", irq[23], 1'b1);
      end
      do_write(A_IPND_H, 12'o4000);
      bus.address = A_HOLE;
      for (int i = 0; i < 4; i++) @(negedge clk);
      vectors++;
      if (irq[23] !== 1'b0) begin
         miscompares++;
         $display("FAIL ext_level irq23 got %b want %b", irq[23], 1'b0);
      end
      do_read(A_IPND_H, d);
      vectors++;
      if (d !== 12'd0) begin
         miscompares++;
         $display("FAIL ext_ipnd_h got %o want %o", d, 12'd0);
      end
   endtask

   task automatic test_reset_mid;
      logic [11:0] d;
      logic [23:0] regs [7];
      regs = '{A_TCNT, A_TRLD, A_TCTL, A_IPND_L, A_IPND_H, A_IMSK_L, A_IMSK_H};
      ext_irq[0] = 1'b1;
      do_write(A_IMSK_L, 12'o7777);
      do_write(A_TCNT, 12'o1234);
      do_write(A_TRLD, 12'o0055);
      do_write(A_TCTL, 12'd2);
      vectors++;
      if (irq !== 24'd2) begin
         miscompares++;
         $display("FAIL premid_irq got %o want %o", irq, 24'd2);
      end
      // Write in flight when reset hits; it must not reach RAM.
      ext_irq = '0;
      bus.address   = 24'o00000005;
      bus.wdata     = 12'o7777;
      bus.mem_write = 1'b1;
      #2 rst = 1'b0;
      @(negedge clk);
      @(negedge clk);
      vectors++;
      if (bus.rdata !== 12'd0) begin
         miscompares++;
         $display("FAIL mid_rdata got %o want %o", bus.rdata, 12'd0);
      end
      vectors++;
      if (irq !== 24'd0) begin
         miscompares++;
         $display("FAIL mid_irq got %o want %o", irq, 24'd0);
      end
      bus.mem_write = 1'b0;
      rst = 1'b1;
      foreach (regs[i]) begin
         do_read(regs[i], d);
         vectors++;
         if (d !== 12'd0) begin
            miscompares++;
            $display("FAIL mid_reg%0d got %o want %o", i, d, 12'd0);
         end
      end
      do_read(A_ID, d);
      vectors++;
      if (d !== 12'o5412) begin
         miscompares++;
         $display("FAIL mid_id got %o want %o", d, 12'o5412);
      end
      do_read(24'o00000005, d);
      vectors++;
      if (d !== 12'o1234) begin
         miscompares++;
         $display("FAIL mid_ram5 got %o want %o", d, 12'o1234);
      end
      do_read(24'o00000007, d);
      vectors++;
      if (d !== 12'o7777) begin
         miscompares++;
         $display("FAIL mid_ram7 got %o want %o", d, 12'o7777);
      end
   endtask

   initial begin
      vectors       = 0;
      miscompares   = 0;
      rst           = 1'b0;
      ext_irq       = '0;
      bus.address   = '0;
      bus.wdata     = '0;
      bus.mem_write = 1'b0;
      test_reset();
      test_ram();
      test_rbw();
      test_timer_oneshot();
      test_timer_reload();
      test_ext_irq();
      test_reset_mid();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
